// File: rtl/auth_block_sequencer.sv
// Block-level sequencer between an AXI-stream block source and a single-block
// MAC/hash compression core; issues one start per block and holds one tag per message.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready to accept the next block from the stream slave
// RUN   | block handed to core, waiting for core_done
// OUT   | final tag presented, waiting for tag_ready handshake
module auth_block_sequencer #(
  parameter int DATA_WIDTH   = 512,
  parameter int DIGEST_WIDTH = 256,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    s_valid,
  input  logic                    s_last,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    core_start,
  output logic                    core_first,
  output logic [DATA_WIDTH-1:0]   core_block,
  input  logic                    core_done,
  input  logic [DIGEST_WIDTH-1:0] core_digest,
  output logic                    tag_valid,
  input  logic                    tag_ready,
  output logic [DIGEST_WIDTH-1:0] tag_out,
  output logic [CNT_WIDTH-1:0]    block_count,
  output logic                    busy,
  output logic                    err_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state;
  logic   first_flag;
  logic   last_flag;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      s_ready      <= 1'b0;
      core_start   <= 1'b0;
      core_first   <= 1'b0;
      core_block   <= '0;
      tag_valid    <= 1'b0;
      tag_out      <= '0;
      block_count  <= '0;
      busy         <= 1'b0;
      err_overflow <= 1'b0;
      first_flag   <= 1'b1;
      last_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid && s_ready) begin
            core_block <= s_data;
            last_flag  <= s_last;
            s_ready    <= 1'b0;
            core_start <= 1'b1;
            core_first <= first_flag;
            busy       <= 1'b1;
            state      <= RUN;
          end else begin
            s_ready <= 1'b1;
          end
        end

        RUN: begin
          core_start <= 1'b0;
          core_first <= 1'b0;
          // A done coincident with our own start pulse belongs to no block of ours.
          if (core_done && !core_start) begin
            if (block_count == CNT_MAX) begin
              err_overflow <= 1'b1;
            end else begin
              block_count <= block_count + 1'b1;
            end
            first_flag <= 1'b0;
            if (last_flag) begin
              tag_out   <= core_digest;
              tag_valid <= 1'b1;
              state     <= OUT;
            end else begin
              s_ready <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
        end

        OUT: begin
          if (tag_ready) begin
            tag_valid   <= 1'b0;
            block_count <= '0;
            first_flag  <= 1'b1;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          s_ready    <= 1'b0;
          core_start <= 1'b0;
          core_first <= 1'b0;
          tag_valid  <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auth_block_sequencer.sv
// Directed bench for auth_block_sequencer; counter width reduced to 2 bits so
// saturation is reachable with a short message.
module tb_auth_block_sequencer;

  localparam int DW = 512;
  localparam int GW = 256;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          resetN;
  logic          s_valid, s_last, s_ready;
  logic [DW-1:0] s_data;
  logic          core_start, core_first, core_done;
  logic [DW-1:0] core_block;
  logic [GW-1:0] core_digest;
  logic          tag_valid, tag_ready;
  logic [GW-1:0] tag_out;
  logic [CW-1:0] block_count;
  logic          busy, err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  auth_block_sequencer #(.DATA_WIDTH(DW), .DIGEST_WIDTH(GW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetN(resetN),
    .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_ready(s_ready),
    .core_start(core_start), .core_first(core_first), .core_block(core_block),
    .core_done(core_done), .core_digest(core_digest),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_out(tag_out),
    .block_count(block_count), .busy(busy), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_first"}, core_first, 0);
    chk({tag, "_core_block"}, core_block, 0);
    chk({tag, "_tag_valid"}, tag_valid, 0);
    chk({tag, "_tag_out"}, tag_out, 0);
    chk({tag, "_block_count"}, block_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_overflow, 0);
  endtask

  // Wait (bounded) for s_ready, then hand over one block and check the start pulse.
  task automatic send_block(input string tag, input logic [DW-1:0] d, input logic last,
                            input logic exp_first);
    int waited = 0;
    while (s_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_ready_wait"}, s_ready, 1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk({tag, "_start"}, core_start, 1);
    chk({tag, "_first"}, core_first, exp_first);
    chk({tag, "_block"}, core_block, d);
    chk({tag, "_s_ready_low"}, s_ready, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  // Leave the start cycle, then pulse core_done and check the outcome.
  task automatic finish_block(input string tag, input logic [GW-1:0] dig, input logic last,
                              input logic [CW-1:0] exp_cnt, input logic exp_err);
    tick();
    chk({tag, "_start_gone"}, core_start, 0);
    core_done   = 1'b1;
    core_digest = dig;
    tick();
    core_done   = 1'b0;
    chk({tag, "_count"}, block_count, exp_cnt);
    chk({tag, "_err"}, err_overflow, exp_err);
    chk({tag, "_tag_valid"}, tag_valid, last);
    chk({tag, "_s_ready"}, s_ready, !last);
    if (last) chk({tag, "_tag_out"}, tag_out, dig);
  endtask

  task automatic accept_tag(input string tag);
    tag_ready = 1'b1;
    tick();
    tag_ready = 1'b0;
    chk({tag, "_tag_valid_clr"}, tag_valid, 0);
    chk({tag, "_count_clr"}, block_count, 0);
    chk({tag, "_s_ready_back"}, s_ready, 1);
    chk({tag, "_busy_clr"}, busy, 0);
  endtask

  initial begin
    logic [DW-1:0] pa, pb, pc;
    logic [GW-1:0] da, db;
    logic [GW-1:0] held_tag;
    logic          stable;

    pa = {16{32'hA5A5A5A5}};
    pb = {16{32'h0F1E2D3C}};
    pc = {16{32'hDEADBEEF}};
    da = {8{32'h12345678}};
    db = {8{32'hCAFEF00D}};

    resetN = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    core_done = 1'b0; core_digest = '0; tag_ready = 1'b0;

    // Reset values, then s_ready on first edge after release
    #12;
    chk_all_zero("reset");
    resetN = 1'b1;
    #1;
    chk("reset_release_ready_low", s_ready, 0);
    @(posedge clk); #1;
    chk("first_edge_ready", s_ready, 1);

    // Single-block message
    send_block("single", pa, 1'b1, 1'b1);
    finish_block("single", da, 1'b1, 2'd1, 1'b0);
    accept_tag("single");

    // Three-block message
    send_block("m3_b1", pa, 1'b0, 1'b1);
    finish_block("m3_b1", db, 1'b0, 2'd1, 1'b0);
    send_block("m3_b2", pb, 1'b0, 1'b0);
    finish_block("m3_b2", db, 1'b0, 2'd2, 1'b0);
    send_block("m3_b3", pc, 1'b1, 1'b0);
    finish_block("m3_b3", da, 1'b1, 2'd3, 1'b0);
    accept_tag("m3");

    // Tag backpressure with s_valid pending
    send_block("bp", pb, 1'b1, 1'b1);
    finish_block("bp", db, 1'b1, 2'd1, 1'b0);
    held_tag = tag_out;
    stable   = 1'b1;
    s_valid = 1'b1; s_data = pc; s_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tag_valid !== 1'b1 || tag_out !== held_tag || s_ready !== 1'b0 || core_start !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_stable_20", stable, 1);
    chk("bp_tag_held", tag_out, db);
    tag_ready = 1'b1;
    tick();
    tag_ready = 1'b0;
    chk("bp_release_ready", s_ready, 1);
    chk("bp_release_tag_clr", tag_valid, 0);
    tick();
    s_valid = 1'b0;
    chk("bp_next_start", core_start, 1);
    chk("bp_next_first", core_first, 1);
    chk("bp_next_block", core_block, pc);
    finish_block("bp_next", da, 1'b0, 2'd1, 1'b0);

    // Spurious core_done in IDLE
    core_done = 1'b1; core_digest = da;
    tick();
    core_done = 1'b0;
    chk("spur_idle_count", block_count, 1);
    chk("spur_idle_tag", tag_valid, 0);
    chk("spur_idle_ready", s_ready, 1);
    chk("spur_idle_busy", busy, 0);

    // Spurious core_done in the core_start cycle (second block of the open message)
    send_block("spur_start", pa, 1'b1, 1'b0);
    core_done = 1'b1; core_digest = da;
    tick();
    core_done = 1'b0;
    chk("spur_start_count", block_count, 1);
    chk("spur_start_tag", tag_valid, 0);
    chk("spur_start_busy", busy, 1);
    chk("spur_start_ready", s_ready, 0);
    core_done = 1'b1; core_digest = db;
    tick();
    core_done = 1'b0;
    chk("spur_real_count", block_count, 2);
    chk("spur_real_tag_valid", tag_valid, 1);
    chk("spur_real_tag_out", tag_out, db);
    accept_tag("spur");

    // Reset during RUN on the second block of a message
    send_block("rst_b1", pa, 1'b0, 1'b1);
    finish_block("rst_b1", da, 1'b0, 2'd1, 1'b0);
    send_block("rst_b2", pb, 1'b0, 1'b0);
    tick();
    #2;
    resetN = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    #3;
    resetN = 1'b1;
    @(posedge clk); #1;
    send_block("post_rst", pc, 1'b1, 1'b1);
    finish_block("post_rst", da, 1'b1, 2'd1, 1'b0);
    accept_tag("post_rst");

    // Saturation with 2-bit counter
    send_block("sat_b1", pa, 1'b0, 1'b1);
    finish_block("sat_b1", da, 1'b0, 2'd1, 1'b0);
    send_block("sat_b2", pb, 1'b0, 1'b0);
    finish_block("sat_b2", da, 1'b0, 2'd2, 1'b0);
    send_block("sat_b3", pc, 1'b0, 1'b0);
    finish_block("sat_b3", da, 1'b0, 2'd3, 1'b0);
    send_block("sat_b4", pa, 1'b0, 1'b0);
    finish_block("sat_b4", da, 1'b0, 2'd3, 1'b1);
    send_block("sat_b5", pb, 1'b1, 1'b0);
    finish_block("sat_b5", db, 1'b1, 2'd3, 1'b1);
    accept_tag("sat");
    chk("sat_err_sticky", err_overflow, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/auth_block_sequencer.md
Name: auth_block_sequencer

Overview:
Controls the flow of 512-bit message blocks from the AXI-stream slave into the single-block MAC/hash compression core, and returns one authentication tag per message. Drives the slave's ready_internal via s_ready and issues one start pulse per block. Marks the first block of each message so the core reinitialises its chaining value. Holds the final digest on a valid/ready tag interface until the consumer accepts it.

Parameters:
DATA_WIDTH, 512, message block width (core block size)
DIGEST_WIDTH, 256, core digest / tag width
CNT_WIDTH, 16, width of the per-message block counter

Ports:
clk  in  1  system clock, all logic on rising edge
resetN  in  1  asynchronous active-low reset
s_valid  in  1  block valid from axi_stream_slave (valid_sys path)
s_last  in  1  block is last of the message, qualified by s_valid
s_data  in  DATA_WIDTH  block data (slave data_out)
s_ready  out  1  to slave ready_internal; sequencer can accept a block
core_start  out  1  one-cycle pulse: process core_block
core_first  out  1  qualified by core_start; first block of message, reinit chaining value
core_block  out  DATA_WIDTH  registered block presented to core
core_done  in  1  one-cycle pulse: core finished current block
core_digest  in  DIGEST_WIDTH  core chaining value, valid when core_done=1
tag_valid  out  1  tag available
tag_ready  in  1  tag consumer accepts
tag_out  out  DIGEST_WIDTH  final message tag
block_count  out  CNT_WIDTH  blocks completed in current message
busy  out  1  state != IDLE
err_overflow  out  1  sticky: block_count saturated

Behaviour:
- Reset (resetN=0, asynchronous): state=IDLE; s_ready, core_start, core_first, tag_valid, busy, err_overflow = 0; core_block, tag_out, block_count = 0; internal first_flag=1, last_flag=0. s_ready rises on first clock edge after reset release.
- All outputs registered. States: IDLE, RUN, OUT.
- IDLE: s_ready=1. Handshake at edge N (s_valid & s_ready) -> core_block<=s_data, last_flag<=s_last, s_ready=0 and core_start=1 in cycle N+1 (exactly one cycle), core_first=first_flag in that cycle, 0 otherwise; state->RUN. No handshake: remain, outputs unchanged.
- RUN: s_ready=0. core_done is ignored in the same cycle core_start is high; it is sampled from the following cycle onward. On core_done:
  - block_count+1. At all-ones it holds and err_overflow<=1 (sticky until reset).
  - first_flag<=0.
  - last_flag=0: state->IDLE, s_ready=1 next cycle.
  - last_flag=1: tag_out<=core_digest, tag_valid<=1, state->OUT.
- No timeout: RUN waits indefinitely for core_done.
- OUT: s_ready=0. tag_valid/tag_out stay stable until tag_ready=1. Handshake -> tag_valid=0, block_count=0, first_flag=1, state->IDLE, s_ready=1 the cycle after handshake.
- Minimum per-block throughput: 1 accept cycle + 1 start cycle + core latency + 1 cycle.
- core_done outside RUN is ignored: no state, count or tag change.
- s_valid while s_ready=0 is not consumed. The slave holds data per AXI-stream rules.
- s_last on a single-block message: core_first=1 and the tag is produced after that block's core_done.
- Reset mid-operation discards the partial message and returns all outputs to their reset values immediately.
- err_overflow does not stop sequencing; the counter simply saturates.

Test Plan:
- Single block: s_data=512'hA5A5..., s_last=1 -> one core_start with core_first=1, cycle after handshake. After core_done with core_digest=256'h1234... -> tag_valid=1, tag_out=256'h1234..., block_count=1. With tag_ready=1 -> IDLE, block_count=0, s_ready=1.
- Three-block message: core_first=1 on block 1 only, 0 on blocks 2-3. s_ready=0 from each handshake until that block's core_done. One tag after block 3, block_count=3.
- Tag backpressure: tag_ready=0 for 20 cycles -> tag_valid/tag_out stable, s_ready=0, s_valid ignored. tag_ready=1 -> next message's first block gets core_first=1.
- Spurious core_done: pulse in IDLE, and in the core_start cycle -> no count change, no tag, state unchanged.
- Reset mid-RUN: resetN=0 while waiting for core_done -> all outputs 0 asynchronously. After release, a new block gets core_first=1.
- Saturation (CNT_WIDTH=2): 5-block message -> block_count 1,2,3,3; err_overflow=1 at the 4th core_done. Tag still produced after block 5.
